// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one write port, zero register, sequential clear engine.
// Latency: reads 0 cycles (optional same-cycle write bypass); writes commit at the rising edge.
// Backpressure: none; Busy is high during clearing, and writes presented then are dropped.
module regfile_param #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clear,
  input  logic [AW-1:0]    RA,
  input  logic [AW-1:0]    RB,
  input  logic [AW-1:0]    RW,
  input  logic [WIDTH-1:0] BusW,
  input  logic             RegWr,
  output logic [WIDTH-1:0] BusA,
  output logic [WIDTH-1:0] BusB,
  output logic             Busy
);

  typedef enum logic {
    CLEARING = 1'b0,
    READY    = 1'b1
  } state_t;

  // A ZERO_REG outside the array means there is no hardwired-zero register at all.
  localparam bit            ZERO_EN  = (ZERO_REG >= 0) && (ZERO_REG < DEPTH);
  localparam logic [AW-1:0] ZERO_IDX = ZERO_EN ? AW'(ZERO_REG) : '0;
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [AW-1:0]    cnt;
  logic [AW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;

  // True for an address that maps to a real, writable register.
  function automatic logic addr_live(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W) && !(ZERO_EN && (a == ZERO_IDX));
  endfunction

  // Read mux shared by both ports: clearing and dead addresses read zero, then bypass, then the array.
  function automatic logic [WIDTH-1:0] rd_port(input logic [AW-1:0] a);
    if ((state == CLEARING) || !addr_live(a)) begin
      return '0;
    end
    if ((BYPASS != 0) && RegWr && !Clear && (RW == a)) begin
      return BusW;
    end
    return mem[a];
  endfunction

  assign Busy  = (state == CLEARING);
  assign wr_ok = (state == READY) && !Clear && RegWr && addr_live(RW);

  // State and clear counter; Reset restarts the clear sweep from register 0.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= CLEARING;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: sweep cnt up to the last register, and re-enter the sweep on a Clear request.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEARING: begin
        if (cnt == LAST_IDX) begin
          state_nxt = READY;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      READY: begin
        if (Clear) begin
          state_nxt = CLEARING;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEARING;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Storage: the clear engine zeroes one register per edge; otherwise accept a qualified write.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (state == CLEARING) begin
        mem[cnt] <= '0;
      end else if (wr_ok) begin
        mem[RW] <= BusW;
      end
    end
  end

  // Operand read ports.
  always_comb begin
    BusA = rd_port(RA);
    BusB = rd_port(RB);
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised successor to the 32 x 64-bit LEGv8 register file. It has two combinational read ports and one write port, and `ZERO_REG` always reads zero. Three things are new relative to that file: a configurable width, depth and zero-register index; optional same-cycle write-to-read bypass; and a sequential clear engine. The clear engine zeroes every register after reset or on request, and signals `Busy` while it runs. The block sits in the decode stage of the pipelined datapath and feeds the operand buses.

## Interface
- `WIDTH`, 64: data width of `BusA`, `BusB` and `BusW`.
- `DEPTH`, 32: number of registers, from 2 to 32.
- `AW`, 5: address width; must satisfy 2^AW >= DEPTH.
- `ZERO_REG`, 31: index hardwired to zero. A value >= `DEPTH` disables the zero register.
- `BYPASS`, 1: 1 forwards `BusW` to a read port in the same cycle; 0 disables forwarding.

Ports:
- `Clk`  in  1  the single clock; all state updates on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Clear`  in  1  request to re-zero all registers.
- `RA`  in  AW  read address, port A.
- `RB`  in  AW  read address, port B.
- `RW`  in  AW  write address.
- `BusW`  in  WIDTH  write data.
- `RegWr`  in  1  write enable.
- `BusA`  out  WIDTH  read data, port A.
- `BusB`  out  WIDTH  read data, port B.
- `Busy`  out  1  high while the clear engine runs; writes are ignored.

## Operation
- Storage: `DEPTH` x `WIDTH` flops. There is no reset value on the array itself; the clear engine initialises it.
- FSM has two states, `CLEARING` and `READY`, plus a clear counter `cnt` (AW bits).
  - `Reset`=1 at an edge: state becomes `CLEARING` and `cnt` becomes 0. This overrides everything else.
  - In `CLEARING`: each edge writes 0 to `reg[cnt]`.
  - In `CLEARING` with `cnt`==`DEPTH`-1: state becomes `READY` after that edge's write.
  - In `CLEARING` otherwise: `cnt` increments.
  - `Clear` while in `CLEARING`: ignored.
  - In `READY` with `Clear`=1: state becomes `CLEARING` and `cnt` becomes 0. A `RegWr` in the same cycle is discarded.
  - In `READY` with `RegWr`=1, `RW` != `ZERO_REG` and `RW` < `DEPTH`: `reg[RW]` takes `BusW`.
- `Busy` = (state == `CLEARING`); it is a registered state decode.
- Read rules for port A; port B is identical with `RB`:
  - `Busy`=1: reads 0.
  - `RA` == `ZERO_REG`, or `RA` >= `DEPTH`: reads 0.
  - `BYPASS`=1 and a write qualifies this cycle (`RegWr`, `RW`==`RA`, state `READY`, `Clear`=0): reads `BusW`.
  - Otherwise: reads `reg[RA]`.
- Writes to `ZERO_REG` or to addresses >= `DEPTH` are silently dropped.
- No arithmetic on data; `BusW` is stored bit-exact.

## Timing
- Reads are combinational from addresses, state and the array. Read latency is 0 cycles.
- Writes commit at the rising edge and are visible to a non-bypassed read from that edge onward.
- Reset values:
  - `Busy`=1 from the first edge with `Reset`=1.
  - `BusA`=`BusB`=0 throughout `CLEARING`.
- Clear duration:
  - After `Reset` deasserts, `Busy` stays 1 for exactly `DEPTH` edges, then is 0.
  - A `Clear` pulse in `READY` gives `Busy`=1 from the next edge, for `DEPTH` edges.
- Boundary cases:
  - `Reset` mid-clear restarts at `cnt`=0, for a full `DEPTH` edges.
  - `Reset` and `Clear` together: `Reset` wins; the result is the same state.
  - `RA`==`RB`==`RW` with bypass: both ports show `BusW`.
  - `RW`==`ZERO_REG` with a matching `RA`: port reads 0 and no bypass occurs.
  - `RegWr` on the final `CLEARING` edge is discarded. The first accepted write is at the first `READY` edge.
  - Only one write per cycle; there is no write-write conflict.

## Test plan
- Default params; pulse `Reset` for 1 edge, then hold 0. Expect `Busy`=1 for 32 edges then 0. Expect `BusA`/`BusB`=0 throughout. Reading all 32 registers afterwards gives 0.
- Write `reg[n]`=n for n=0..31, then read pairs (0,1), (2,3) … (30,31) with `RegWr`=0. Expect `BusA`=even n and `BusB`=odd n, except register 31 reads 0.
- `RA`=13, `RW`=13, `RegWr`=1, `BusW`=0xabcd:
  - `BYPASS`=1: `BusA`=0xabcd before the edge.
  - `BYPASS`=0: `BusA`=0xd before the edge, 0xabcd after it.
- Write 0x1010 to register 31 (dropped, still reads 0) and 0x103000 to register 11. Then pulse `Clear` with `RegWr`=1, `RW`=12. Expect `Busy`=1 for 32 edges, register 12 unchanged-then-cleared, and register 11=0 afterwards.
- Assert `Reset` at `cnt`=10 during a clear. Expect `Busy` to remain 1 for 32 further edges after release.
- `DEPTH`=24, `WIDTH`=32, `ZERO_REG`=0:
  - write 0xffffffff to register 30: dropped; reading register 30 gives 0.
  - write 0xffffffff to register 23: reads back 0xffffffff.
  - register 0 reads 0 after a write of 5.
